// File: rtl/mem_access_unit.sv
// MEM-stage control: runs data-memory loads/stores over a req/ack
// handshake, stalls upstream while an access is outstanding, registers
// the MEM/WB outputs and drives the branch-taken PC select.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_write_data_mem,
    input  logic [4:0]  in_rd,
    input  logic        in_zero_flag,
    input  logic        in_branch,
    input  logic        in_regwrite,
    input  logic        in_memtoreg,
    input  logic        in_memread,
    input  logic        in_memwrite,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        out_stall,
    output logic        out_pcsrc,
    output logic [31:0] out_read_data,
    output logic [31:0] out_alu_result,
    output logic [4:0]  out_rd,
    output logic        out_regwrite,
    output logic        out_memtoreg,
    output logic        out_fault
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        req_d, we_d, fault_d;
    logic [31:0] addr_d, wdata_d;
    logic [31:0] rdata_d, alu_d;
    logic [4:0]  rd_d;
    logic        rw_d, m2r_d;

    logic access, misaligned;

    assign access     = in_memread | in_memwrite;
    assign misaligned = |in_alu_result[1:0];

    // Branch select is never masked: branches carry no memory access.
    assign out_pcsrc = in_branch & in_zero_flag;

    // Next-state, next-register values and the combinational stall.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_d     = dmem_req;
        we_d      = dmem_we;
        addr_d    = dmem_addr;
        wdata_d   = dmem_wdata;
        rdata_d   = out_read_data;
        alu_d     = out_alu_result;
        rd_d      = out_rd;
        rw_d      = out_regwrite;
        m2r_d     = out_memtoreg;
        fault_d   = out_fault;
        out_stall = 1'b0;

        case (state_q)
            IDLE: begin
                if (!access) begin
                    rdata_d = '0;
                    alu_d   = in_alu_result;
                    rd_d    = in_rd;
                    rw_d    = in_regwrite;
                    m2r_d   = in_memtoreg;
                end else if (misaligned) begin
                    rdata_d = '0;
                    alu_d   = in_alu_result;
                    rd_d    = in_rd;
                    rw_d    = 1'b0;
                    m2r_d   = in_memtoreg;
                    fault_d = 1'b1;
                end else begin
                    out_stall = 1'b1;
                    req_d     = 1'b1;
                    we_d      = in_memwrite;
                    addr_d    = in_alu_result;
                    wdata_d   = in_write_data_mem;
                    cnt_d     = '0;
                    rdata_d   = '0;
                    alu_d     = '0;
                    rd_d      = '0;
                    rw_d      = 1'b0;
                    m2r_d     = 1'b0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                out_stall = 1'b1;
                // EX/MEM is frozen by the stall, so its fields still
                // describe the outstanding access here.
                if (dmem_ack) begin
                    req_d   = 1'b0;
                    rdata_d = in_memread ? dmem_rdata : '0;
                    alu_d   = in_alu_result;
                    rd_d    = in_rd;
                    rw_d    = in_regwrite;
                    m2r_d   = in_memtoreg;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    rdata_d = '0;
                    alu_d   = in_alu_result;
                    rd_d    = in_rd;
                    rw_d    = 1'b0;
                    m2r_d   = in_memtoreg;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                rdata_d = '0;
                alu_d   = '0;
                rd_d    = '0;
                rw_d    = 1'b0;
                m2r_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter and all registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            out_read_data  <= '0;
            out_alu_result <= '0;
            out_rd         <= '0;
            out_regwrite   <= 1'b0;
            out_memtoreg   <= 1'b0;
            out_fault      <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            dmem_req       <= req_d;
            dmem_we        <= we_d;
            dmem_addr      <= addr_d;
            dmem_wdata     <= wdata_d;
            out_read_data  <= rdata_d;
            out_alu_result <= alu_d;
            out_rd         <= rd_d;
            out_regwrite   <= rw_d;
            out_memtoreg   <= m2r_d;
            out_fault      <= fault_d;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table for non-memory ops and
// branch select, hand sequences for load/store/timeout/misaligned/reset.
module tb_mem_access_unit;

    logic        clock;
    logic        reset_n;
    logic [31:0] in_alu_result;
    logic [31:0] in_write_data_mem;
    logic [4:0]  in_rd;
    logic        in_zero_flag, in_branch;
    logic        in_regwrite, in_memtoreg, in_memread, in_memwrite;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic        out_stall, out_pcsrc;
    logic [31:0] out_read_data, out_alu_result;
    logic [4:0]  out_rd;
    logic        out_regwrite, out_memtoreg, out_fault;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .in_alu_result     (in_alu_result),
        .in_write_data_mem (in_write_data_mem),
        .in_rd             (in_rd),
        .in_zero_flag      (in_zero_flag),
        .in_branch         (in_branch),
        .in_regwrite       (in_regwrite),
        .in_memtoreg       (in_memtoreg),
        .in_memread        (in_memread),
        .in_memwrite       (in_memwrite),
        .dmem_req          (dmem_req),
        .dmem_we           (dmem_we),
        .dmem_addr         (dmem_addr),
        .dmem_wdata        (dmem_wdata),
        .dmem_rdata        (dmem_rdata),
        .dmem_ack          (dmem_ack),
        .out_stall         (out_stall),
        .out_pcsrc         (out_pcsrc),
        .out_read_data     (out_read_data),
        .out_alu_result    (out_alu_result),
        .out_rd            (out_rd),
        .out_regwrite      (out_regwrite),
        .out_memtoreg      (out_memtoreg),
        .out_fault         (out_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        br;
        logic        zf;
        logic        exp_pcsrc;
        logic [4:0]  exp_rd;
        logic        exp_rw;
        logic        exp_m2r;
        logic [31:0] exp_alu;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_nop();
        in_alu_result     = '0;
        in_write_data_mem = '0;
        in_rd             = '0;
        in_zero_flag      = 1'b0;
        in_branch         = 1'b0;
        in_regwrite       = 1'b0;
        in_memtoreg       = 1'b0;
        in_memread        = 1'b0;
        in_memwrite       = 1'b0;
    endtask

    // Runs one aligned access; k = ack delay in cycles after req rises, -1 = never.
    task automatic do_access(input string tag, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [4:0] rd, input logic rw,
                             input logic m2r, input int k, input logic [31:0] rdata,
                             input int exp_req, input int exp_stall,
                             input logic [31:0] exp_rdata, input logic exp_rw);
        int   req_cnt   = 0;
        int   stall_cnt = 0;
        logic hold_ok   = 1'b1;
        logic done      = 1'b0;
        @(negedge clock);
        in_memread        = ~wr;
        in_memwrite       = wr;
        in_alu_result     = addr;
        in_write_data_mem = wdata;
        in_rd             = rd;
        in_regwrite       = rw;
        in_memtoreg       = m2r;
        dmem_rdata        = rdata;
        dmem_ack          = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (c > 0 && !out_stall) begin
                done     = 1'b1;
                dmem_ack = 1'b0;
            end else begin
                if (out_stall) stall_cnt++;
                if (dmem_req) begin
                    req_cnt++;
                    if (dmem_addr !== addr || dmem_wdata !== wdata || dmem_we !== wr)
                        hold_ok = 1'b0;
                end
                dmem_ack = dmem_req && (k >= 0) && (req_cnt == k + 1);
                @(negedge clock);
            end
        end
        check({tag, " reached_done"}, {31'b0, done}, 32'd1);
        check({tag, " req_cycles"}, req_cnt, exp_req);
        check({tag, " stall_cycles"}, stall_cnt, exp_stall);
        check({tag, " dmem_hold"}, {31'b0, hold_ok}, 32'd1);
        check({tag, " done_req"}, {31'b0, dmem_req}, 32'd0);
        check({tag, " read_data"}, out_read_data, exp_rdata);
        check({tag, " alu_result"}, out_alu_result, addr);
        check({tag, " rd"}, {27'b0, out_rd}, {27'b0, rd});
        check({tag, " regwrite"}, {31'b0, out_regwrite}, {31'b0, exp_rw});
        check({tag, " memtoreg"}, {31'b0, out_memtoreg}, {31'b0, m2r});
        set_nop();
        @(negedge clock);
        #1;
        check({tag, " bubble_regwrite"}, {31'b0, out_regwrite}, 32'd0);
        check({tag, " bubble_rd"}, {27'b0, out_rd}, 32'd0);
        check({tag, " bubble_alu"}, out_alu_result, 32'd0);
        check({tag, " bubble_rdata"}, out_read_data, 32'd0);
        check({tag, " bubble_req"}, {31'b0, dmem_req}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        alu           rd  rw m2r br zf  pcs exp_rd rw m2r exp_alu
        vecs[0] = '{32'h0000_1234, 5'd5,  1, 0, 0, 0, 0, 5'd5,  1, 0, 32'h0000_1234};
        vecs[1] = '{32'hFFFF_FFFF, 5'd31, 1, 0, 1, 1, 1, 5'd31, 1, 0, 32'hFFFF_FFFF};
        vecs[2] = '{32'h0000_0000, 5'd0,  0, 0, 1, 0, 0, 5'd0,  0, 0, 32'h0000_0000};
        vecs[3] = '{32'h8000_0001, 5'd17, 1, 0, 0, 1, 0, 5'd17, 1, 0, 32'h8000_0001};
        vecs[4] = '{32'hCAFE_F00D, 5'd1,  0, 1, 1, 1, 1, 5'd1,  0, 1, 32'hCAFE_F00D};

        reset_n    = 1'b0;
        dmem_ack   = 1'b0;
        dmem_rdata = '0;
        set_nop();
        #12;
        check("reset dmem_req", {31'b0, dmem_req}, 32'd0);
        check("reset dmem_addr", dmem_addr, 32'd0);
        check("reset out_rd", {27'b0, out_rd}, 32'd0);
        check("reset out_fault", {31'b0, out_fault}, 32'd0);
        check("reset out_stall", {31'b0, out_stall}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Non-memory ops: one-cycle EX/MEM -> MEM/WB, no stall, pcsrc same cycle.
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            in_alu_result = vecs[i].alu;
            in_rd         = vecs[i].rd;
            in_regwrite   = vecs[i].rw;
            in_memtoreg   = vecs[i].m2r;
            in_branch     = vecs[i].br;
            in_zero_flag  = vecs[i].zf;
            #1;
            check($sformatf("vec%0d pcsrc", i), {31'b0, out_pcsrc}, {31'b0, vecs[i].exp_pcsrc});
            check($sformatf("vec%0d stall", i), {31'b0, out_stall}, 32'd0);
            @(negedge clock);
            #1;
            check($sformatf("vec%0d rd", i), {27'b0, out_rd}, {27'b0, vecs[i].exp_rd});
            check($sformatf("vec%0d regwrite", i), {31'b0, out_regwrite}, {31'b0, vecs[i].exp_rw});
            check($sformatf("vec%0d memtoreg", i), {31'b0, out_memtoreg}, {31'b0, vecs[i].exp_m2r});
            check($sformatf("vec%0d alu", i), out_alu_result, vecs[i].exp_alu);
            check($sformatf("vec%0d rdata", i), out_read_data, 32'd0);
        end
        set_nop();

        do_access("load", 1'b0, 32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b1, 3,
                  32'hDEAD_BEEF, 4, 5, 32'hDEAD_BEEF, 1'b1);
        do_access("store", 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 5'd0, 1'b0, 1'b0, 0,
                  32'h1111_1111, 1, 2, 32'h0, 1'b0);
        check("store fault", {31'b0, out_fault}, 32'd0);

        do_access("timeout", 1'b0, 32'h0000_0200, 32'h0, 5'd9, 1'b1, 1'b1, -1,
                  32'h5555_5555, 4, 5, 32'h0, 1'b0);
        check("timeout fault", {31'b0, out_fault}, 32'd1);

        // Stray ack in IDLE is ignored.
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h7777_7777;
        #1;
        check("late_ack stall", {31'b0, out_stall}, 32'd0);
        @(negedge clock);
        dmem_ack = 1'b0;
        #1;
        check("late_ack req", {31'b0, dmem_req}, 32'd0);
        check("late_ack rdata", out_read_data, 32'd0);

        do_access("after_to", 1'b0, 32'h0000_0300, 32'h0, 5'd4, 1'b1, 1'b1, 1,
                  32'h0BAD_F00D, 2, 3, 32'h0BAD_F00D, 1'b1);
        check("after_to fault", {31'b0, out_fault}, 32'd1);

        // Reset during the second BUSY cycle.
        @(negedge clock);
        in_memread    = 1'b1;
        in_alu_result = 32'h0000_0080;
        in_rd         = 5'd2;
        in_regwrite   = 1'b1;
        in_memtoreg   = 1'b1;
        @(negedge clock);
        #1;
        check("rst_mid req_before", {31'b0, dmem_req}, 32'd1);
        @(negedge clock);
        reset_n = 1'b0;
        set_nop();
        #1;
        check("rst_mid req", {31'b0, dmem_req}, 32'd0);
        check("rst_mid addr", dmem_addr, 32'd0);
        check("rst_mid fault", {31'b0, out_fault}, 32'd0);
        check("rst_mid rdata", out_read_data, 32'd0);
        check("rst_mid stall", {31'b0, out_stall}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Misaligned load: no request, no stall, fault set.
        @(negedge clock);
        in_memread    = 1'b1;
        in_alu_result = 32'h0000_0102;
        in_rd         = 5'd3;
        in_regwrite   = 1'b1;
        #1;
        check("misalign stall", {31'b0, out_stall}, 32'd0);
        @(negedge clock);
        set_nop();
        #1;
        check("misalign req", {31'b0, dmem_req}, 32'd0);
        check("misalign fault", {31'b0, out_fault}, 32'd1);
        check("misalign regwrite", {31'b0, out_regwrite}, 32'd0);
        check("misalign rd", {27'b0, out_rd}, 32'd3);
        check("misalign rdata", out_read_data, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
